medfilt_window_ctrl: RTL and testbench
======================================

# medfilt_window_ctrl

Sequencing controller for the 3x3 median-filter front end. It accepts a raster pixel stream and drives the shift enable and write data of the two cascaded line buffers. It flushes the pipeline at end of frame and tells the window/sorter stage when a centred 3x3 window is valid, including its position and which edges need padding. It is the only block that advances the line buffers.

## Interface
Parameters:
- DATA_WIDTH, 8, pixel width
- IMG_W, 640, pixels per line (≥4)
- IMG_H, 512, lines per frame (≥2)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- s_valid  in  1  input pixel valid
- s_ready  out  1  input pixel accepted when s_valid && s_ready
- s_data  in  DATA_WIDTH  input pixel
- s_sof  in  1  start of frame, qualifies the first pixel
- m_ready  in  1  downstream can take a window this cycle
- lb_shift  out  1  advance both line buffers and the window registers (line buffer in_valid)
- lb_data  out  DATA_WIDTH  data written into the line-buffer chain
- win_valid  out  1  centred window valid
- win_row  out  $clog2(IMG_H)  centre row
- win_col  out  $clog2(IMG_W)  centre column
- win_border  out  4  {top, bottom, left, right} pad flags
- frame_done  out  1  one-cycle pulse after the last window
- err_sof  out  1  one-cycle pulse on a mid-frame s_sof

## Operation
- State machine:
  - IDLE -> FILL: on an accepted pixel with s_sof.
  - FILL -> STREAM: after IMG_W+1 accepted pixels.
  - STREAM -> FLUSH: on the accepted pixel at (IMG_H-1, IMG_W-1).
  - FLUSH -> IDLE: after IMG_W+1 flush shifts.
- s_ready = m_ready in IDLE, FILL and STREAM; s_ready = 0 in FLUSH.
- IDLE: pixels without s_sof are accepted and discarded, with lb_shift = 0.
- lb_shift:
  - Asserted for each accepted pixel in FILL/STREAM, and for the s_sof pixel in IDLE.
  - In FLUSH, asserted every cycle m_ready = 1.
- lb_data = s_data on input shifts, 0 on flush shifts.
- Input position counter (row, col) advances per accepted pixel; col wraps at IMG_W-1, row increments on the wrap.
- Output position counter starts at (0,0). It advances once per shift that occurs while in STREAM or FLUSH, and once for the FILL->STREAM transition shift (the (IMG_W+1)-th pixel).
- Each output advance produces one window.
- Total windows per frame = IMG_W*IMG_H. Total shifts per frame = IMG_W*IMG_H + IMG_W + 1.
- win_border:
  - top = (win_row == 0), bottom = (win_row == IMG_H-1)
  - left = (win_col == 0), right = (win_col == IMG_W-1)
- Mid-frame s_sof (accepted in FILL or STREAM):
  - That pixel becomes (0,0) of a new frame; both counters reset; state goes to FILL.
  - err_sof pulses; no frame_done for the aborted frame.
  - Stale line-buffer rows are covered by the top flag.
- frame_done pulses the cycle after the final window's win_valid.
- Reset mid-frame: counters cleared, state IDLE, all outputs low, and no flush is issued. Line-buffer contents are don't-care.

## Timing
- Reset values: s_ready = 0, lb_shift = 0, lb_data = 0, win_valid = 0, win_row = 0, win_col = 0, win_border = 0, frame_done = 0, err_sof = 0.
- s_ready and lb_shift are combinational from state and m_ready/s_valid. lb_data is combinational.
- win_valid, win_row, win_col and win_border are registered. They assert the cycle after the qualifying lb_shift, matching the 1-cycle line-buffer read latency.
- No skid buffer: m_ready gates shifting directly, so a window is produced only if m_ready was high at its shift.
- Back-to-back frames: s_sof can be accepted in the first IDLE cycle after FLUSH. Minimum gap is IMG_W+1 cycles at m_ready = 1.

## Structure
- Package medfilt_pkg:
  - ctrl_state_t enum {IDLE, FILL, STREAM, FLUSH}
  - border bit indices (BORDER_TOP=3 … BORDER_RIGHT=0)
  - localparams WIN_K = 3 and FILL_LEN = IMG_W+1, expressed as a function of IMG_W
- Sub-module raster_cnt (parameters W, H; inputs en and clr; outputs row, col, last_col, last_pix). Instantiated twice: one input counter, one output counter.

## Test plan
- 8x4 frame, s_valid and m_ready always high:
  - First win_valid comes 1 cycle after the 9th accepted pixel, with (0,0) and border 4'b1010.
  - 32 windows total.
  - FLUSH issues 9 shifts with lb_data = 0.
  - frame_done comes one cycle after window (3,7), which has border 4'b0101.
- Same frame with m_ready toggling 1010…:
  - lb_shift never asserts while m_ready = 0.
  - Window count stays 32 and the sequence is identical.
- Pixels without s_sof in IDLE: s_ready = 1, lb_shift = 0, and no windows are produced.
- s_sof asserted at pixel 20 of an 8x4 frame:
  - err_sof pulses and the counters restart.
  - 32 windows follow with (0,0) first; no frame_done for the aborted frame.
- rst_n low for one cycle in mid-STREAM: all outputs 0 the next cycle, state IDLE. The next s_sof frame completes normally.
- Two consecutive frames: the second s_sof is held until FLUSH ends (s_ready = 0 for 9 cycles), then 32 more windows follow.

Source files
------------

// File: rtl/medfilt_pkg.sv
// Shared types and constants for the 3x3 median-filter front end.
package medfilt_pkg;

    // Controller phases: waiting for a frame, priming the line buffers,
    // producing windows from live pixels, draining the tail of the frame.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL   = 2'd1,
        STREAM = 2'd2,
        FLUSH  = 2'd3
    } ctrl_state_t;

    // Bit positions inside the window border-flag vector.
    localparam int BORDER_TOP    = 3;
    localparam int BORDER_BOTTOM = 2;
    localparam int BORDER_LEFT   = 1;
    localparam int BORDER_RIGHT  = 0;

    // Window edge length.
    localparam int WIN_K = 3;

    // Number of pixels that must be in the line-buffer chain before the first
    // centred window exists: half a window of full lines plus half a window
    // of pixels. For a 3x3 window this is IMG_W+1.
    function automatic int fill_len(input int img_w);
        return (WIN_K / 2) * img_w + (WIN_K / 2);
    endfunction

endpackage

// File: rtl/medfilt_window_ctrl_raster_cnt.sv
// Raster position counter: column runs 0..W-1, row advances on each column
// wrap and itself wraps after H-1. clr returns to the origin; when clr and en
// are both high the origin is counted, leaving the counter at (0,1).
module raster_cnt #(
    parameter int W = 640,
    parameter int H = 512
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 clr,
    output logic [$clog2(H)-1:0] row,
    output logic [$clog2(W)-1:0] col,
    output logic                 last_col,
    output logic                 last_pix
);

    localparam int RW = $clog2(H);
    localparam int CW = $clog2(W);

    logic [RW-1:0] row_reg;
    logic [RW-1:0] row_next;
    logic [RW-1:0] base_row;
    logic [CW-1:0] col_reg;
    logic [CW-1:0] col_next;
    logic [CW-1:0] base_col;

    // Next position: optionally clear to the origin, then optionally step.
    always_comb begin
        base_row = clr ? '0 : row_reg;
        base_col = clr ? '0 : col_reg;
        row_next = base_row;
        col_next = base_col;
        if (en) begin
            if (base_col == CW'(W - 1)) begin
                col_next = '0;
                row_next = (base_row == RW'(H - 1)) ? '0 : base_row + 1'b1;
            end else begin
                col_next = base_col + 1'b1;
            end
        end
    end

    // Position register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_reg <= '0;
            col_reg <= '0;
        end else begin
            row_reg <= row_next;
            col_reg <= col_next;
        end
    end

    assign row      = row_reg;
    assign col      = col_reg;
    assign last_col = (col_reg == CW'(W - 1));
    assign last_pix = last_col && (row_reg == RW'(H - 1));

endmodule

// File: rtl/medfilt_window_ctrl.sv
// Sequencing controller for the 3x3 median-filter front end: drives the
// line-buffer shift/data, flushes at end of frame and reports each centred
// window with its position and padding flags.
module medfilt_window_ctrl
    import medfilt_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 512
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [DATA_WIDTH-1:0]    s_data,
    input  logic                     s_sof,
    input  logic                     m_ready,
    output logic                     lb_shift,
    output logic [DATA_WIDTH-1:0]    lb_data,
    output logic                     win_valid,
    output logic [$clog2(IMG_H)-1:0] win_row,
    output logic [$clog2(IMG_W)-1:0] win_col,
    output logic [3:0]               win_border,
    output logic                     frame_done,
    output logic                     err_sof
);

    localparam int RW       = $clog2(IMG_H);
    localparam int CW       = $clog2(IMG_W);
    localparam int FILL_LEN = fill_len(IMG_W);
    // Raster position of the FILL_LEN-th pixel; the same position marks the
    // final flush shift once the input counter has wrapped past the frame.
    localparam int FILL_ROW = (FILL_LEN - 1) / IMG_W;
    localparam int FILL_COL = (FILL_LEN - 1) % IMG_W;

    ctrl_state_t state_reg;
    ctrl_state_t state_next;

    logic          accept;
    logic          sof_accept;
    logic          abort;
    logic          in_shift;
    logic          flush_shift;
    logic          fill_hit;
    logic          win_adv;
    logic          in_en;
    logic          in_clr;
    logic          out_clr;

    logic [RW-1:0] in_row;
    logic [CW-1:0] in_col;
    logic          in_last_col_unused;
    logic          in_last_pix;
    logic [RW-1:0] out_row;
    logic [CW-1:0] out_col;
    logic          out_last_col;
    logic          out_last_pix;

    logic [3:0]    border_next;

    logic          win_valid_reg;
    logic [RW-1:0] win_row_reg;
    logic [CW-1:0] win_col_reg;
    logic [3:0]    win_border_reg;
    logic          win_last_reg;
    logic          frame_done_reg;
    logic          err_sof_reg;

    // Input counter: where the next accepted pixel sits in the raster.
    raster_cnt #(.W(IMG_W), .H(IMG_H)) u_in_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (in_en),
        .clr      (in_clr),
        .row      (in_row),
        .col      (in_col),
        .last_col (in_last_col_unused),
        .last_pix (in_last_pix)
    );

    // Output counter: centre position of the next window to be produced.
    raster_cnt #(.W(IMG_W), .H(IMG_H)) u_out_cnt (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (win_adv),
        .clr      (out_clr),
        .row      (out_row),
        .col      (out_col),
        .last_col (out_last_col),
        .last_pix (out_last_pix)
    );

    // Handshake, shift and window-advance decode; next-state selection.
    always_comb begin
        s_ready     = rst_n && m_ready && (state_reg != FLUSH);
        accept      = s_valid && s_ready;
        sof_accept  = accept && s_sof;
        abort       = sof_accept && (state_reg == FILL || state_reg == STREAM);
        // In IDLE only the start-of-frame pixel enters the line buffers.
        in_shift    = accept && ((state_reg == FILL) || (state_reg == STREAM) || s_sof);
        flush_shift = rst_n && m_ready && (state_reg == FLUSH);
        lb_shift    = in_shift || flush_shift;
        lb_data     = in_shift ? s_data : '0;
        fill_hit    = (in_row == RW'(FILL_ROW)) && (in_col == CW'(FILL_COL));

        win_adv    = 1'b0;
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (sof_accept) state_next = FILL;
            end
            FILL: begin
                if (abort) begin
                    state_next = FILL;
                end else if (in_shift && fill_hit) begin
                    win_adv    = 1'b1;
                    state_next = STREAM;
                end
            end
            STREAM: begin
                if (abort) begin
                    state_next = FILL;
                end else if (in_shift) begin
                    win_adv = 1'b1;
                    if (in_last_pix) state_next = FLUSH;
                end
            end
            FLUSH: begin
                // The last flush shift only pushes the tail through; it
                // completes no further window.
                if (flush_shift) begin
                    if (fill_hit) state_next = IDLE;
                    else          win_adv    = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        in_en   = in_shift || (flush_shift && !fill_hit);
        in_clr  = sof_accept || (flush_shift && fill_hit);
        out_clr = sof_accept || (flush_shift && fill_hit);
    end

    // Padding flags of the window about to be issued.
    always_comb begin
        border_next                = '0;
        border_next[BORDER_TOP]    = (out_row == '0);
        border_next[BORDER_BOTTOM] = (out_row == RW'(IMG_H - 1));
        border_next[BORDER_LEFT]   = (out_col == '0);
        border_next[BORDER_RIGHT]  = out_last_col;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Window descriptor and status pulses, one cycle behind the shift to line
    // up with the line-buffer read latency.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_valid_reg  <= 1'b0;
            win_row_reg    <= '0;
            win_col_reg    <= '0;
            win_border_reg <= '0;
            win_last_reg   <= 1'b0;
            frame_done_reg <= 1'b0;
            err_sof_reg    <= 1'b0;
        end else begin
            win_valid_reg  <= win_adv;
            if (win_adv) begin
                win_row_reg    <= out_row;
                win_col_reg    <= out_col;
                win_border_reg <= border_next;
            end
            win_last_reg   <= win_adv && out_last_pix;
            frame_done_reg <= win_last_reg;
            err_sof_reg    <= abort;
        end
    end

    assign win_valid  = win_valid_reg;
    assign win_row    = win_row_reg;
    assign win_col    = win_col_reg;
    assign win_border = win_border_reg;
    assign frame_done = frame_done_reg;
    assign err_sof    = err_sof_reg;

endmodule

// File: tb/tb_medfilt_window_ctrl.sv
// Scoreboard bench for medfilt_window_ctrl on an 8x4 frame: stimulus pushes
// expected window/done/error events, a monitor pops them as the DUT reports.
module tb_medfilt_window_ctrl;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int DW = 8;

    localparam int EV_WIN  = 0;
    localparam int EV_DONE = 1;
    localparam int EV_ERR  = 2;

    typedef struct {
        int         kind;
        int         row;
        int         col;
        logic [3:0] border;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          s_sof;
    logic          m_ready;
    logic          lb_shift;
    logic [DW-1:0] lb_data;
    logic          win_valid;
    logic [1:0]    win_row;
    logic [2:0]    win_col;
    logic [3:0]    win_border;
    logic          frame_done;
    logic          err_sof;

    int  checks = 0;
    int  errors = 0;
    int  mode   = 0;      // 0: m_ready held high, 1: m_ready toggles
    int  flush_cnt = 0;
    int  stalls;
    ev_t q[$];

    medfilt_window_ctrl #(.DATA_WIDTH(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_data     (s_data),
        .s_sof      (s_sof),
        .m_ready    (m_ready),
        .lb_shift   (lb_shift),
        .lb_data    (lb_data),
        .win_valid  (win_valid),
        .win_row    (win_row),
        .win_col    (win_col),
        .win_border (win_border),
        .frame_done (frame_done),
        .err_sof    (err_sof)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endfunction

    function automatic void push_win(int k);
        ev_t e;
        e.kind   = EV_WIN;
        e.row    = k / W;
        e.col    = k % W;
        e.border = {e.row == 0, e.row == H - 1, e.col == 0, e.col == W - 1};
        q.push_back(e);
    endfunction

    function automatic void push_tag(int kind);
        ev_t e;
        e.kind   = kind;
        e.row    = 0;
        e.col    = 0;
        e.border = '0;
        q.push_back(e);
    endfunction

    function automatic void push_frame();
        for (int k = 0; k < W * H; k++) push_win(k);
        push_tag(EV_DONE);
    endfunction

    // Pops the next expected event and checks it has the given kind.
    function automatic bit pop_expect(int kind, string name, output ev_t e);
        e.kind = -1; e.row = 0; e.col = 0; e.border = '0;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got unexpected event expected none", name);
            return 1'b0;
        end
        e = q.pop_front();
        chk({name, "_kind"}, kind, e.kind);
        return (e.kind == kind);
    endfunction

    // Drives m_ready away from the active edge.
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_ready = (mode == 0) ? 1'b1 : ~m_ready;
        end
    end

    // Monitor: per-cycle shift checks and scoreboard comparison.
    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                flush_cnt = 0;
            end else begin
                if (lb_shift) begin
                    chk("shift_without_m_ready", m_ready, 1);
                    if (s_valid && s_ready) begin
                        chk("lb_data_input", lb_data, s_data);
                    end else begin
                        chk("lb_data_flush", lb_data, 0);
                        flush_cnt++;
                    end
                end
                if (err_sof) void'(pop_expect(EV_ERR, "err_sof", e));
                if (win_valid) begin
                    if (pop_expect(EV_WIN, "win", e)) begin
                        chk("win_row", win_row, e.row);
                        chk("win_col", win_col, e.col);
                        chk("win_border", win_border, e.border);
                    end
                end
                if (frame_done) begin
                    void'(pop_expect(EV_DONE, "frame_done", e));
                    chk("flush_shift_count", flush_cnt, W + 1);
                    flush_cnt = 0;
                end
            end
        end
    end

    // Offers one pixel and returns after the edge that accepts it.
    task automatic send(input logic [DW-1:0] d, input logic sof, output int n_stall);
        s_valid = 1'b1;
        s_data  = d;
        s_sof   = sof;
        n_stall = 0;
        @(negedge clk);
        while (!s_ready) begin
            n_stall++;
            if (n_stall > 200) begin
                $display("FAIL handshake_timeout: got no s_ready expected s_ready within 200 cycles");
                $fatal(1);
            end
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        s_sof   = 1'b0;
    endtask

    task automatic send_pixels(input int n, input int base, output int first_stall);
        int st;
        first_stall = 0;
        for (int p = 0; p < n; p++) begin
            send(DW'(base + p * 5), p == 0, st);
            if (p == 0) first_stall = st;
        end
    endtask

    task automatic wait_empty(input int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        if (q.size() != 0) chk("drain_timeout_pending", q.size(), 0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_sof   = 1'b0;
        s_data  = '0;

        // Reset values while reset is held (m_ready is high).
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_s_ready", s_ready, 0);
        chk("rst_lb_shift", lb_shift, 0);
        chk("rst_lb_data", lb_data, 0);
        chk("rst_win_valid", win_valid, 0);
        chk("rst_win_row", win_row, 0);
        chk("rst_win_col", win_col, 0);
        chk("rst_win_border", win_border, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_err_sof", err_sof, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // IDLE discards pixels that carry no start-of-frame.
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1;
            s_sof   = 1'b0;
            s_data  = DW'(8'hA0 + i);
            @(negedge clk);
            chk("idle_s_ready", s_ready, 1);
            chk("idle_lb_shift", lb_shift, 0);
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Full frame, m_ready always high.
        push_frame();
        send_pixels(W * H, 11, stalls);
        wait_empty(200);

        // Same frame with m_ready toggling.
        mode = 1;
        push_frame();
        send_pixels(W * H, 11, stalls);
        wait_empty(400);
        mode = 0;
        repeat (2) @(posedge clk);
        #1;

        // Start-of-frame at pixel 20 aborts the frame and restarts it.
        for (int k = 0; k < 19 - W; k++) push_win(k);
        push_tag(EV_ERR);
        push_frame();
        send_pixels(19, 40, stalls);
        send_pixels(W * H, 90, stalls);
        wait_empty(200);

        // One-cycle reset in the middle of STREAM.
        for (int k = 0; k < 15 - W; k++) push_win(k);
        send_pixels(15, 7, stalls);
        repeat (3) @(posedge clk);
        #1;
        chk("pre_reset_pending", q.size(), 0);
        s_valid = 1'b1;
        s_sof   = 1'b1;
        rst_n   = 1'b0;
        @(negedge clk);
        chk("midrst_s_ready", s_ready, 0);
        chk("midrst_lb_shift", lb_shift, 0);
        chk("midrst_lb_data", lb_data, 0);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        s_valid = 1'b0;
        s_sof   = 1'b0;
        @(negedge clk);
        chk("postrst_win_valid", win_valid, 0);
        chk("postrst_win_row", win_row, 0);
        chk("postrst_win_col", win_col, 0);
        chk("postrst_win_border", win_border, 0);
        chk("postrst_frame_done", frame_done, 0);
        chk("postrst_err_sof", err_sof, 0);
        chk("postrst_lb_shift", lb_shift, 0);
        @(posedge clk);
        #1;
        push_frame();
        send_pixels(W * H, 3, stalls);
        wait_empty(200);

        // Back-to-back frames: the second start-of-frame waits out the flush.
        push_frame();
        push_frame();
        send_pixels(W * H, 21, stalls);
        send_pixels(W * H, 55, stalls);
        chk("sof_stall_cycles", stalls, W + 1);
        wait_empty(200);

        chk("queue_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
